// File: rtl/demux_sequencer_if.sv
// Word source / frame consumer handshake plus the demux drive signals of demux_sequencer.
interface demux_sequencer_if #(
  parameter int unsigned MUX_SEL = 2,
  parameter int unsigned DDW     = 16
);
  localparam int unsigned NDEST = 1 << MUX_SEL;

  logic [DDW-1:0]     i_data;
  logic               i_valid;
  logic               o_ready;
  logic               i_ack;
  logic [MUX_SEL-1:0] o_sel;
  logic [DDW-1:0]     o_bus;
  logic [NDEST-1:0]   o_load;
  logic               o_frame_done;
  logic               o_err;

  // Master is the word source / frame consumer; slave is the sequencer.
  modport master (
    output i_data, i_valid, i_ack,
    input  o_ready, o_sel, o_bus, o_load, o_frame_done, o_err
  );

  modport slave (
    input  i_data, i_valid, i_ack,
    output o_ready, o_sel, o_bus, o_load, o_frame_done, o_err
  );
endinterface

// File: rtl/demux_sequencer.sv
// Steers the words of a frame to consecutive demux destinations, then waits for the
// consumer to acknowledge the frame; aborts a frame that stalls between words.
module demux_sequencer #(
  parameter int unsigned MUX_SEL   = 2,
  parameter int unsigned DDW       = 16,
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned TIMEOUT   = 1000
) (
  input logic              i_clk,
  input logic              i_rst,
  demux_sequencer_if.slave dmx
);
  localparam int unsigned NDEST = 1 << MUX_SEL;
  localparam int unsigned CW    = $clog2(TIMEOUT);

  localparam logic [MUX_SEL-1:0] LAST_IDX   = MUX_SEL'(NUM_WORDS - 1);
  localparam logic [CW-1:0]      IDLE_LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state;
  logic [MUX_SEL-1:0] idx;
  logic [CW-1:0]      idle_cnt;
  logic               xfer_c;

  // o_ready is registered, so a handshake is simply valid while ready.
  assign xfer_c = dmx.i_valid & dmx.o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= S_IDLE;
      idx              <= '0;
      idle_cnt         <= '0;
      dmx.o_ready      <= 1'b1;
      dmx.o_sel        <= '0;
      dmx.o_bus        <= '0;
      dmx.o_load       <= '0;
      dmx.o_frame_done <= 1'b0;
      dmx.o_err        <= 1'b0;
    end else begin
      dmx.o_load <= '0;
      dmx.o_err  <= 1'b0;

      // Every accepted word drives the demux for exactly one cycle; bus/sel then hold.
      if (xfer_c) begin
        dmx.o_bus  <= dmx.i_data;
        dmx.o_sel  <= idx;
        dmx.o_load <= NDEST'(1) << idx;
      end

      unique case (state)
        S_IDLE, S_COLLECT: begin
          if (xfer_c) begin
            idle_cnt <= '0;
            if (idx == LAST_IDX) begin
              state            <= S_DONE;
              dmx.o_ready      <= 1'b0;
              dmx.o_frame_done <= 1'b1;
            end else begin
              state <= S_COLLECT;
              idx   <= idx + 1'b1;
            end
          end else if (state == S_COLLECT) begin
            // A word arriving on the limit cycle wins over the abort (handled above).
            if (idle_cnt == IDLE_LIMIT) begin
              state       <= S_ERR;
              dmx.o_ready <= 1'b0;
              dmx.o_err   <= 1'b1;
              idx         <= '0;
              idle_cnt    <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          if (dmx.i_ack) begin
            state            <= S_IDLE;
            idx              <= '0;
            dmx.o_ready      <= 1'b1;
            dmx.o_frame_done <= 1'b0;
          end
        end

        S_ERR: begin
          state       <= S_IDLE;
          dmx.o_ready <= 1'b1;
        end

        default: begin
          state       <= S_IDLE;
          dmx.o_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_demux_sequencer.sv
// Directed bench for demux_sequencer: default frame, gaps, timeout abort, DONE hold,
// mid-frame reset, single-word frames and a wider selector.
module tb_demux_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] acc3 = 8'h00;
  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  demux_sequencer_if #(.MUX_SEL(2), .DDW(16)) if0 ();
  demux_sequencer_if #(.MUX_SEL(2), .DDW(16)) if1 ();
  demux_sequencer_if #(.MUX_SEL(2), .DDW(16)) if2 ();
  demux_sequencer_if #(.MUX_SEL(3), .DDW(16)) if3 ();

  demux_sequencer #(.MUX_SEL(2), .DDW(16), .NUM_WORDS(4), .TIMEOUT(1000))
    u0 (.i_clk(clk), .i_rst(rst), .dmx(if0));
  demux_sequencer #(.MUX_SEL(2), .DDW(16), .NUM_WORDS(4), .TIMEOUT(8))
    u1 (.i_clk(clk), .i_rst(rst), .dmx(if1));
  demux_sequencer #(.MUX_SEL(2), .DDW(16), .NUM_WORDS(1), .TIMEOUT(8))
    u2 (.i_clk(clk), .i_rst(rst), .dmx(if2));
  demux_sequencer #(.MUX_SEL(3), .DDW(16), .NUM_WORDS(5), .TIMEOUT(8))
    u3 (.i_clk(clk), .i_rst(rst), .dmx(if3));

  // Every destination ever loaded on the wide-selector instance.
  always @(negedge clk) acc3 <= acc3 | if3.o_load;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk0(input string tag, input logic rdy, input logic [1:0] sel,
                      input logic [15:0] bus, input logic [3:0] load,
                      input logic done, input logic err);
    chk({tag, ".ready"}, 32'(if0.o_ready), 32'(rdy));
    chk({tag, ".sel"},   32'(if0.o_sel),   32'(sel));
    chk({tag, ".bus"},   32'(if0.o_bus),   32'(bus));
    chk({tag, ".load"},  32'(if0.o_load),  32'(load));
    chk({tag, ".done"},  32'(if0.o_frame_done), 32'(done));
    chk({tag, ".err"},   32'(if0.o_err),   32'(err));
  endtask

  initial begin
    rst = 1'b1;
    if0.i_valid = 1'b0; if0.i_data = '0; if0.i_ack = 1'b0;
    if1.i_valid = 1'b0; if1.i_data = '0; if1.i_ack = 1'b0;
    if2.i_valid = 1'b0; if2.i_data = '0; if2.i_ack = 1'b0;
    if3.i_valid = 1'b0; if3.i_data = '0; if3.i_ack = 1'b0;

    // Reset with a word presented: it must be discarded.
    if0.i_valid = 1'b1; if0.i_data = 16'hdead;
    tick();
    chk0("reset", 1'b1, 2'd0, 16'h0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;

    // Back-to-back default frame.
    if0.i_data = 16'h1111; tick(); chk0("w0", 1'b1, 2'd0, 16'h1111, 4'b0001, 1'b0, 1'b0);
    if0.i_data = 16'h2222; tick(); chk0("w1", 1'b1, 2'd1, 16'h2222, 4'b0010, 1'b0, 1'b0);
    if0.i_data = 16'h3333; tick(); chk0("w2", 1'b1, 2'd2, 16'h3333, 4'b0100, 1'b0, 1'b0);
    if0.i_data = 16'h4444; tick(); chk0("w3", 1'b0, 2'd3, 16'h4444, 4'b1000, 1'b1, 1'b0);

    // DONE ignores valid until acknowledged.
    if0.i_data = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      tick(); chk0("done_hold", 1'b0, 2'd3, 16'h4444, 4'b0000, 1'b1, 1'b0);
    end
    if0.i_valid = 1'b0; if0.i_ack = 1'b1;
    tick(); chk0("ack", 1'b1, 2'd3, 16'h4444, 4'b0000, 1'b0, 1'b0);
    if0.i_ack = 1'b0;

    // Frame with a 5-cycle gap; ack during COLLECT must be ignored.
    if0.i_valid = 1'b1;
    if0.i_data = 16'haaaa; tick(); chk0("g_w0", 1'b1, 2'd0, 16'haaaa, 4'b0001, 1'b0, 1'b0);
    if0.i_data = 16'hbbbb; tick(); chk0("g_w1", 1'b1, 2'd1, 16'hbbbb, 4'b0010, 1'b0, 1'b0);
    if0.i_valid = 1'b0; if0.i_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); chk0("gap", 1'b1, 2'd1, 16'hbbbb, 4'b0000, 1'b0, 1'b0);
    end
    if0.i_ack = 1'b0; if0.i_valid = 1'b1;
    if0.i_data = 16'hcccc; tick(); chk0("g_w2", 1'b1, 2'd2, 16'hcccc, 4'b0100, 1'b0, 1'b0);
    if0.i_data = 16'hdddd; tick(); chk0("g_w3", 1'b0, 2'd3, 16'hdddd, 4'b1000, 1'b1, 1'b0);
    if0.i_valid = 1'b0; if0.i_ack = 1'b1;
    tick(); chk0("g_ack", 1'b1, 2'd3, 16'hdddd, 4'b0000, 1'b0, 1'b0);
    if0.i_ack = 1'b0;

    // Reset in the middle of a frame.
    if0.i_valid = 1'b1;
    if0.i_data = 16'h0101; tick();
    if0.i_data = 16'h0202; tick(); chk0("r_w1", 1'b1, 2'd1, 16'h0202, 4'b0010, 1'b0, 1'b0);
    if0.i_valid = 1'b0; rst = 1'b1;
    tick(); chk0("r_mid", 1'b1, 2'd0, 16'h0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0; if0.i_valid = 1'b1;
    if0.i_data = 16'h0303; tick(); chk0("r_after", 1'b1, 2'd0, 16'h0303, 4'b0001, 1'b0, 1'b0);
    if0.i_valid = 1'b0;

    // TIMEOUT=8: two words then silence aborts 8 cycles after the last transfer.
    if1.i_valid = 1'b1;
    if1.i_data = 16'h0011; tick();
    if1.i_data = 16'h0022; tick(); chk("t_w1.load", 32'(if1.o_load), 32'h2);
    if1.i_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t_wait.err", 32'(if1.o_err), 32'h0);
      chk("t_wait.done", 32'(if1.o_frame_done), 32'h0);
    end
    tick();
    chk("t_err.err", 32'(if1.o_err), 32'h1);
    chk("t_err.ready", 32'(if1.o_ready), 32'h0);
    chk("t_err.done", 32'(if1.o_frame_done), 32'h0);
    tick();
    chk("t_post.err", 32'(if1.o_err), 32'h0);
    chk("t_post.ready", 32'(if1.o_ready), 32'h1);
    chk("t_post.done", 32'(if1.o_frame_done), 32'h0);
    if1.i_valid = 1'b1; if1.i_data = 16'h0033;
    tick();
    chk("t_next.load", 32'(if1.o_load), 32'h1);
    chk("t_next.sel", 32'(if1.o_sel), 32'h0);
    if1.i_valid = 1'b0;
    // A word on the limit cycle wins over the abort.
    repeat (7) tick();
    if1.i_valid = 1'b1; if1.i_data = 16'h0044;
    tick();
    chk("t_prio.load", 32'(if1.o_load), 32'h2);
    chk("t_prio.err", 32'(if1.o_err), 32'h0);
    if1.i_valid = 1'b0;
    tick();
    chk("t_prio2.err", 32'(if1.o_err), 32'h0);
    chk("t_prio2.ready", 32'(if1.o_ready), 32'h1);

    // NUM_WORDS=1: every word goes to destination 0 and completes the frame.
    if2.i_valid = 1'b1; if2.i_data = 16'h0a0a;
    tick();
    chk("s_w0.load", 32'(if2.o_load), 32'h1);
    chk("s_w0.done", 32'(if2.o_frame_done), 32'h1);
    chk("s_w0.ready", 32'(if2.o_ready), 32'h0);
    if2.i_valid = 1'b0; if2.i_ack = 1'b1;
    tick();
    chk("s_ack.done", 32'(if2.o_frame_done), 32'h0);
    chk("s_ack.ready", 32'(if2.o_ready), 32'h1);
    if2.i_ack = 1'b0; if2.i_valid = 1'b1; if2.i_data = 16'h0b0b;
    tick();
    chk("s_w1.load", 32'(if2.o_load), 32'h1);
    chk("s_w1.sel", 32'(if2.o_sel), 32'h0);
    chk("s_w1.bus", 32'(if2.o_bus), 32'h0b0b);
    chk("s_w1.done", 32'(if2.o_frame_done), 32'h1);
    if2.i_valid = 1'b0;

    // MUX_SEL=3, NUM_WORDS=5: only destinations 0..4 may load.
    if3.i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if3.i_data = 16'(i + 16'h100);
      tick();
      chk("m_w.load", 32'(if3.o_load), 32'(1 << i));
      chk("m_w.sel", 32'(if3.o_sel), 32'(i));
    end
    chk("m_done", 32'(if3.o_frame_done), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("m_hold.load", 32'(if3.o_load), 32'h0);
    end
    if3.i_valid = 1'b0; if3.i_ack = 1'b1;
    tick();
    if3.i_ack = 1'b0;
    tick();
    chk("m_acc", 32'(acc3), 32'h1f);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/demux_sequencer.md
DEMUX_SEQUENCER -- requirements
Module: demux_sequencer

Interface
REQ-001 Parameter MUX_SEL, default 2, selector width; destinations = 2**MUX_SEL.
REQ-002 Parameter DDW, default 16, data word width.
REQ-003 Parameter NUM_WORDS, default 4, words per frame; legal range 1..2**MUX_SEL.
REQ-004 Parameter TIMEOUT, default 1000, idle cycles allowed between words inside a frame; legal range >= 2.
REQ-005 i_clk  in  1  single clock; all logic on rising edge.
REQ-006 i_rst  in  1  reset; synchronous, active-high.
REQ-007 i_data  in  DDW  incoming word.
REQ-008 i_valid  in  1  i_data valid this cycle.
REQ-009 o_ready  out  1  block accepts a word this cycle.
REQ-010 i_ack  in  1  consumer has taken the completed frame.
REQ-011 o_sel  out  MUX_SEL  destination index driven to the demux selector.
REQ-012 o_bus  out  DDW  registered word driven to the demux bus input.
REQ-013 o_load  out  2**MUX_SEL  one-hot load strobe, bit k = destination k.
REQ-014 o_frame_done  out  1  level; frame complete, awaiting i_ack.
REQ-015 o_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-016 The block SHALL implement states IDLE, COLLECT, DONE, ERR.
REQ-017 A word transfers when i_valid and o_ready are both 1 on a rising edge.
REQ-018 o_ready SHALL be 1 in IDLE and COLLECT, and 0 in DONE and ERR.
REQ-019 Each transfer SHALL register i_data into o_bus and the word index into o_sel, and assert o_load[index] for exactly the next cycle; all other o_load bits are 0.
REQ-020 Transfer-to-o_load latency SHALL be one cycle.
REQ-021 o_bus and o_sel SHALL hold their values until the next transfer.
REQ-022 The word index SHALL start at 0 for every frame and increment by 1 per transfer; the first word goes to destination 0 and word n to destination n.
REQ-023 IDLE + transfer -> COLLECT when NUM_WORDS > 1, and -> DONE when NUM_WORDS = 1.
REQ-024 COLLECT + transfer of the word with index NUM_WORDS-1 -> DONE.
REQ-025 In COLLECT, an idle counter SHALL clear on every transfer and increment on every cycle without one.
REQ-026 COLLECT with the idle counter reaching TIMEOUT-1 and no transfer this cycle -> ERR.
REQ-027 A transfer in the same cycle as the limit is reached SHALL take priority; no abort occurs.
REQ-028 DONE: o_frame_done = 1; i_ack -> IDLE with the index cleared; i_ack outside DONE SHALL be ignored.
REQ-029 ERR: o_err = 1 for exactly one cycle, the index clears, o_frame_done stays 0; next state IDLE.
REQ-030 An aborted partial frame SHALL NOT be reported as done, and already-issued loads are not retracted.
REQ-031 i_valid while o_ready = 0 SHALL be ignored: no load and no state change.
REQ-032 Destinations with index >= NUM_WORDS SHALL never receive o_load.
REQ-033 The index and idle counter SHALL be sized so they never wrap within a legal frame.

Reset
REQ-034 While i_rst = 1 at a clock edge, the next state SHALL be IDLE, overriding all other conditions, including mid-frame and in DONE.
REQ-035 Reset values: o_ready = 1 after the reset cycle; o_sel = 0; o_bus = 0; o_load = 0; o_frame_done = 0; o_err = 0; index = 0; idle counter = 0.
REQ-036 A transfer presented in a reset cycle SHALL be discarded.

Verification
REQ-037 Defaults, words 0x1111/0x2222/0x3333/0x4444 back-to-back -> o_load 0001, 0010, 0100, 1000 on consecutive cycles with matching o_bus/o_sel; o_frame_done = 1 with o_ready = 0 until i_ack; then IDLE.
REQ-038 Frame with a 5-cycle gap between word 1 and word 2 -> no error; same four loads; frame done.
REQ-039 TIMEOUT=8, two words then silence -> o_err pulse 8 cycles after the last transfer; o_frame_done never 1; next word loads destination 0.
REQ-040 DONE held with i_valid = 1 for 10 cycles, no i_ack -> no o_load; i_ack -> next word to destination 0.
REQ-041 i_rst pulsed after word 2 of a frame -> all outputs at reset values; the following word loads destination 0.
REQ-042 NUM_WORDS=1 -> each word loads destination 0 and enters DONE; MUX_SEL=3, NUM_WORDS=5 -> only o_load bits 0..4 ever assert.
